// File: rtl/div_seq_ctrl_pkg.sv
// Shared types and constants for the program-2 divide sequencer.
package div_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RD0,
        RD1,
        RD2,
        RD3,
        DIV,
        WR0,
        WR1,
        WR2,
        DONE
    } state_t;

    localparam int          QUOT_W      = 24;
    localparam int          ITER_LAST   = 23;
    localparam logic [23:0] DIV0_RESULT = 24'hFFFFFF;

endpackage

// File: rtl/div_step_dp.sv
// Restoring-divide datapath: one quotient bit per step, MSB of the numerator first.
module div_step_dp
    import div_seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              step,
    input  logic [QUOT_W-1:0] n,
    input  logic [7:0]        divisor,
    output logic [QUOT_W-1:0] q
);

    logic [QUOT_W-1:0] n_q, n_d;
    logic [QUOT_W-1:0] q_q, q_d;
    logic [8:0]        r_q, r_d;
    logic [7:0]        div_q, div_d;
    logic [8:0]        r_shift;
    logic              fits;

    // Remainder stays below the divisor, so its low 8 bits carry the whole value.
    assign r_shift = {r_q[7:0], n_q[QUOT_W-1]};
    assign fits    = (r_shift >= {1'b0, div_q});

    always_comb begin
        n_d   = n_q;
        q_d   = q_q;
        r_d   = r_q;
        div_d = div_q;
        if (load) begin
            n_d   = n;
            q_d   = '0;
            r_d   = '0;
            div_d = divisor;
        end else if (step) begin
            n_d = {n_q[QUOT_W-2:0], 1'b0};
            r_d = fits ? (r_shift - {1'b0, div_q}) : r_shift;
            q_d = {q_q[QUOT_W-2:0], fits};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q   <= '0;
            q_q   <= '0;
            r_q   <= '0;
            div_q <= '0;
        end else begin
            n_q   <= n_d;
            q_q   <= q_d;
            r_q   <= r_d;
            div_q <= div_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer for the 16/8 fixed-point divide: operand fetch, 24-step divide,
// result write-back, and the Start/Ack handshake.
module div_seq_ctrl
    import div_seq_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int OPA_BASE  = 0,
    parameter int RES_BASE  = 4,
    parameter int FRAC_BITS = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic              Ack,
    output logic              Busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic [7:0]        mem_wr_data,
    output logic              mem_wr_en
);

    localparam int LAST_ITER = 16 + FRAC_BITS - 1;

    state_t            state_q, state_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [7:0]        dvd_hi_q, dvd_hi_d;
    logic [7:0]        dvd_lo_q, dvd_lo_d;
    logic              div0_q, div0_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_en_q, wr_en_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              dp_load, dp_step;
    logic [QUOT_W-1:0] dp_q;
    logic [QUOT_W-1:0] quot;

    div_step_dp u_dp (
        .clk     (Clk),
        .rst     (Reset),
        .load    (dp_load),
        .step    (dp_step),
        .n       ({dvd_hi_q, dvd_lo_q, {FRAC_BITS{1'b0}}}),
        .divisor (mem_rd_data),
        .q       (dp_q)
    );

    assign quot = div0_q ? DIV0_RESULT : dp_q;

    // Read data lags the address by one cycle, so each byte is captured a state later.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dvd_hi_d = dvd_hi_q;
        dvd_lo_d = dvd_lo_q;
        div0_d   = div0_q;
        addr_d   = addr_q;
        wr_en_d  = wr_en_q;
        ack_d    = ack_q;
        busy_d   = busy_q;
        dp_load  = 1'b0;
        dp_step  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (Start) begin
                    state_d = RD0;
                    addr_d  = ADDR_W'(OPA_BASE);
                    div0_d  = 1'b0;
                    ack_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            RD0: begin
                state_d = RD1;
                addr_d  = ADDR_W'(OPA_BASE + 1);
                dp_load = 1'b1;
            end
            RD1: begin
                state_d  = RD2;
                addr_d   = ADDR_W'(OPA_BASE + 2);
                dvd_hi_d = mem_rd_data;
            end
            RD2: begin
                state_d  = RD3;
                dvd_lo_d = mem_rd_data;
            end
            RD3: begin
                dp_load = 1'b1;
                cnt_d   = '0;
                if (mem_rd_data != 8'd0) begin
                    state_d = DIV;
                end else begin
                    state_d = WR0;
                    div0_d  = 1'b1;
                    addr_d  = ADDR_W'(RES_BASE);
                    wr_en_d = 1'b1;
                end
            end
            DIV: begin
                dp_step = 1'b1;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'(LAST_ITER)) begin
                    state_d = WR0;
                    addr_d  = ADDR_W'(RES_BASE);
                    wr_en_d = 1'b1;
                end
            end
            WR0: begin
                state_d = WR1;
                addr_d  = ADDR_W'(RES_BASE + 1);
            end
            WR1: begin
                state_d = WR2;
                addr_d  = ADDR_W'(RES_BASE + 2);
            end
            WR2: begin
                state_d = DONE;
                wr_en_d = 1'b0;
                ack_d   = 1'b1;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                wr_en_d = 1'b0;
                ack_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            dvd_hi_q <= '0;
            dvd_lo_q <= '0;
            div0_q   <= 1'b0;
            addr_q   <= '0;
            wr_en_q  <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dvd_hi_q <= dvd_hi_d;
            dvd_lo_q <= dvd_lo_d;
            div0_q   <= div0_d;
            addr_q   <= addr_d;
            wr_en_q  <= wr_en_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        mem_wr_data = 8'd0;
        case (state_q)
            WR0:     mem_wr_data = quot[23:16];
            WR1:     mem_wr_data = quot[15:8];
            WR2:     mem_wr_data = quot[7:0];
            default: mem_wr_data = 8'd0;
        endcase
    end

    assign mem_addr  = addr_q;
    assign mem_wr_en = wr_en_q;
    assign Ack       = ack_q;
    assign Busy      = busy_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl with a synchronous-read byte memory model.
module tb_div_seq_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Start = 1'b0;
    logic       Ack;
    logic       Busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;

    logic [7:0] mem [0:255];
    logic       tb_we = 1'b0;
    logic [7:0] tb_addr = 8'd0;
    logic [7:0] tb_data = 8'd0;
    int         wr_count = 0;
    int         checks = 0;
    int         errors = 0;

    div_seq_ctrl #(
        .ADDR_W(8), .OPA_BASE(0), .RES_BASE(4), .FRAC_BITS(8)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Start       (Start),
        .Ack         (Ack),
        .Busy        (Busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_data (mem_wr_data),
        .mem_wr_en   (mem_wr_en)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_wr_en) begin
            mem[mem_addr] <= mem_wr_data;
            wr_count      <= wr_count + 1;
        end else if (tb_we) begin
            mem[tb_addr] <= tb_data;
        end
        mem_rd_data <= mem[mem_addr];
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge Clk);
        tb_addr = a;
        tb_data = d;
        tb_we   = 1'b1;
        @(posedge Clk);
        #1;
        tb_we = 1'b0;
    endtask

    // Launch one divide, time Ack from the launch edge, then inspect results.
    task automatic run_div(input logic [15:0] dvd, input logic [7:0] dvs,
                           input logic [23:0] exp_q, input int exp_lat, input string name);
        int base;
        int lat;
        logic [23:0] got;
        poke(8'd0, dvd[15:8]);
        poke(8'd1, dvd[7:0]);
        poke(8'd2, dvs);
        poke(8'd4, 8'hAA);
        poke(8'd5, 8'hAA);
        poke(8'd6, 8'hAA);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        base = wr_count;
        #1;
        Start = 1'b0;
        checks++;
        if (Ack !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s launch: Ack=%b Busy=%b, required Ack=0 Busy=1", name, Ack, Busy);
        end
        lat = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge Clk);
            #1;
            if (Ack === 1'b1) begin
                lat = c;
                break;
            end
        end
        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d, required %0d", name, lat, exp_lat);
        end
        @(negedge Clk);
        got = {mem[4], mem[5], mem[6]};
        checks++;
        if (got !== exp_q) begin
            errors++;
            $display("FAIL %s result: got %06h, required %06h", name, got, exp_q);
        end
        checks++;
        if ((wr_count - base) !== 3 || Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s strobes/busy: strobes=%0d Busy=%b, required 3 and 0",
                     name, wr_count - base, Busy);
        end
        $display("run %s: %04h / %02h -> %06h, Ack after %0d cycles", name, dvd, dvs, got, lat);
    endtask

    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        checks++;
        if (Ack !== 1'b0 || Busy !== 1'b0 || mem_wr_en !== 1'b0 ||
            mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: Ack=%b Busy=%b we=%b addr=%h wd=%h, required all 0",
                     Ack, Busy, mem_wr_en, mem_addr, mem_wr_data);
        end
        @(negedge Clk);
        Reset = 1'b0;
        $display("reset: outputs idle");
    endtask

    task automatic test_divide();
        run_div(16'd12800, 8'd25,  24'h020000, 31, "12800/25");
        run_div(16'd3,     8'd255, 24'h000003, 31, "3/255");
        run_div(16'hFFFF,  8'd1,   24'hFFFF00, 31, "FFFF/1");
        run_div(16'd1,     8'd255, 24'h000001, 31, "1/255");
        run_div(16'd1,     8'd2,   24'h000080, 31, "1/2");
    endtask

    task automatic test_div_zero();
        run_div(16'h1234, 8'd0, 24'hFFFFFF, 7, "1234/0");
    endtask

    task automatic test_reset_mid_div();
        int base;
        logic [23:0] got;
        poke(8'd0, 8'h32);
        poke(8'd1, 8'h00);
        poke(8'd2, 8'd25);
        poke(8'd4, 8'h55);
        poke(8'd5, 8'h55);
        poke(8'd6, 8'h55);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        base = wr_count;
        #1;
        Start = 1'b0;
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if (Ack !== 1'b0 || Busy !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div async: Ack=%b Busy=%b we=%b, required 0 0 0",
                     Ack, Busy, mem_wr_en);
        end
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (40) @(posedge Clk);
        #1;
        got = {mem[4], mem[5], mem[6]};
        checks++;
        if (got !== 24'h555555 || wr_count !== base || Ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div memory: got %06h strobes=%0d Ack=%b, required 555555 0 0",
                     got, wr_count - base, Ack);
        end
        $display("reset mid-div: mem[4..6]=%06h", got);
        run_div(16'd12800, 8'd25, 24'h020000, 31, "relaunch");
    endtask

    task automatic test_back_to_back();
        int base;
        int lat1;
        int lat2;
        logic [23:0] got;
        poke(8'd0, 8'h32);
        poke(8'd1, 8'h00);
        poke(8'd2, 8'd25);
        poke(8'd4, 8'h00);
        poke(8'd5, 8'h00);
        poke(8'd6, 8'h00);
        @(negedge Clk);
        Start = 1'b1;
        @(posedge Clk);
        base = wr_count;
        lat1 = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge Clk);
            #1;
            if (Ack === 1'b1) begin
                lat1 = c;
                break;
            end
        end
        @(posedge Clk);
        #1;
        checks++;
        if (lat1 !== 31 || Ack !== 1'b0 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b relaunch: lat=%0d Ack=%b Busy=%b, required 31 0 1", lat1, Ack, Busy);
        end
        lat2 = 0;
        for (int c = 1; c <= 80; c++) begin
            @(posedge Clk);
            #1;
            if (Ack === 1'b1) begin
                lat2 = c;
                break;
            end
        end
        Start = 1'b0;
        @(negedge Clk);
        got = {mem[4], mem[5], mem[6]};
        checks++;
        if (lat2 !== 31 || got !== 24'h020000 || (wr_count - base) !== 6) begin
            errors++;
            $display("FAIL b2b second run: lat=%0d result=%06h strobes=%0d, required 31 020000 6",
                     lat2, got, wr_count - base);
        end
        $display("back-to-back: lat1=%0d lat2=%0d result=%06h", lat1, lat2, got);
    endtask

    initial begin
        test_reset();
        test_divide();
        test_div_zero();
        test_reset_mid_div();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
